// File: rtl/i2c_target_core.sv
// ---------------------------------------------------------------------------
// i2c_target_core
//   I2C target (slave) byte engine. Synchronises SCL/SDA from the pads,
//   detects START/STOP, matches a 7-bit device address and then either
//   delivers received write bytes or serialises read bytes supplied by a
//   byte-wide client. No clock stretching; general call is never matched.
//
// Ports
//   clk, rst_n  system clock (>= 8x SCL), async active-low reset
//   scl_in      SCL pad input (asynchronous)
//   sda_in      SDA pad input (asynchronous)
//   sda_oe      1 = pull SDA low, 0 = release (open-drain pad)
//   rx_data     last byte received in a write transfer
//   rx_valid    one-clk pulse when rx_data updates
//   tx_data     next byte to send in a read transfer
//   tx_req      one-clk pulse when tx_data is captured
//   rw          R/W bit of the current matched transfer
//   busy        high from an address match until STOP or NACK
// ---------------------------------------------------------------------------
module i2c_target_core #(
  parameter logic [6:0]  TARGET_ADDR = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       rw,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP
  } state_t;

  // ------------------------------------------------------------------
  // Pad synchronisers plus one history flop for edge detection
  // ------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, sda_rise, sda_fall;
  logic                   start_det, stop_det;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: synchroniser flops reset to the idle bus level (1), so leaving
      // reset with a quiet bus produces no spurious edges.
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // flop samples the pre-edge value of its neighbours.
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  =  scl_s & ~scl_d;
  assign scl_fall  = ~scl_s &  scl_d;
  assign sda_rise  =  sda_s & ~sda_d;
  assign sda_fall  = ~sda_s &  sda_d;
  assign start_det = sda_fall & scl_s;
  assign stop_det  = sda_rise & scl_s;

  // ------------------------------------------------------------------
  // Protocol FSM: register process + combinational next-state process
  // ------------------------------------------------------------------
  state_t     state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shift, shift_nxt;
  logic [7:0] tx_shift, tx_shift_nxt;
  // byte_done marks "8th rise seen" (ADDR/RX/TX) or "master ACKed" (TX_ACK);
  // needed because bit_cnt has already wrapped back to 0 at that point.
  logic       byte_done, byte_done_nxt;
  logic       sda_oe_nxt, rx_valid_nxt, tx_req_nxt, rw_nxt, busy_nxt;
  logic [7:0] rx_data_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
      tx_shift  <= 8'h00;
      byte_done <= 1'b0;
      sda_oe    <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      rw        <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift     <= shift_nxt;
      tx_shift  <= tx_shift_nxt;
      byte_done <= byte_done_nxt;
      sda_oe    <= sda_oe_nxt;
      rx_data   <= rx_data_nxt;
      rx_valid  <= rx_valid_nxt;
      tx_req    <= tx_req_nxt;
      rw        <= rw_nxt;
      busy      <= busy_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path can
    // leave it unassigned and infer a latch.
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shift_nxt     = shift;
    tx_shift_nxt  = tx_shift;
    byte_done_nxt = byte_done;
    sda_oe_nxt    = sda_oe;
    rx_data_nxt   = rx_data;
    rx_valid_nxt  = 1'b0;
    tx_req_nxt    = 1'b0;
    rw_nxt        = rw;
    busy_nxt      = busy;

    if (start_det) begin
      state_nxt     = ADDR;
      bit_cnt_nxt   = 3'd0;
      byte_done_nxt = 1'b0;
      sda_oe_nxt    = 1'b0;
      busy_nxt      = 1'b0;
    end else if (stop_det) begin
      state_nxt     = IDLE;
      bit_cnt_nxt   = 3'd0;
      byte_done_nxt = 1'b0;
      sda_oe_nxt    = 1'b0;
      busy_nxt      = 1'b0;
    end else begin
      case (state)
        IDLE: ;

        ADDR, RX: begin
          if (scl_rise) begin
            shift_nxt   = {shift[6:0], sda_s};
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              byte_done_nxt = 1'b1;
              if (state == RX) begin
                rx_data_nxt  = {shift[6:0], sda_s};
                rx_valid_nxt = 1'b1;
              end
            end
          end else if (scl_fall && byte_done) begin
            byte_done_nxt = 1'b0;
            if (state == RX) begin
              sda_oe_nxt = 1'b1;
              state_nxt  = RX_ACK;
            end else if (shift[7:1] == TARGET_ADDR && shift[7:1] != 7'd0) begin
              sda_oe_nxt = 1'b1;
              rw_nxt     = shift[0];
              busy_nxt   = 1'b1;
              state_nxt  = ADDR_ACK;
            end else begin
              state_nxt  = WAIT_STOP;
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_nxt = 3'd0;
            if (rw) begin
              tx_shift_nxt = tx_data;
              tx_req_nxt   = 1'b1;
              sda_oe_nxt   = ~tx_data[7];
              state_nxt    = TX;
            end else begin
              sda_oe_nxt   = 1'b0;
              state_nxt    = RX;
            end
          end
        end

        RX_ACK: begin
          if (scl_fall) begin
            sda_oe_nxt = 1'b0;
            state_nxt  = RX;
          end
        end

        TX: begin
          if (scl_rise) begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) byte_done_nxt = 1'b1;
          end else if (scl_fall) begin
            if (byte_done) begin
              byte_done_nxt = 1'b0;
              sda_oe_nxt    = 1'b0;
              state_nxt     = TX_ACK;
            end else begin
              // bit_cnt counts bits already clocked out, MSB first
              sda_oe_nxt = ~tx_shift[3'd7 - bit_cnt];
            end
          end
        end

        TX_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              busy_nxt  = 1'b0;
              state_nxt = WAIT_STOP;
            end else begin
              byte_done_nxt = 1'b1;
            end
          end else if (scl_fall && byte_done) begin
            byte_done_nxt = 1'b0;
            tx_shift_nxt  = tx_data;
            tx_req_nxt    = 1'b1;
            sda_oe_nxt    = ~tx_data[7];
            bit_cnt_nxt   = 3'd0;
            state_nxt     = TX;
          end
        end

        WAIT_STOP: sda_oe_nxt = 1'b0;

        default: begin
          state_nxt  = IDLE;
          sda_oe_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_core.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_core
//   Bus-level bench: a behavioural I2C master drives SCL/SDA onto a wired-AND
//   bus, a client process feeds tx_data from a byte pool, and a monitor pops
//   expected rx bytes / tx captures from scoreboard queues whenever the DUT
//   pulses rx_valid or tx_req.
// ---------------------------------------------------------------------------
module tb_i2c_target_core;

  localparam logic [6:0] OWN_ADDR = 7'h50;
  localparam int         Q        = 40;   // quarter SCL period (4 clk)

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl_m, sda_m;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       rw;
  logic       busy;

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_target_core dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_in   (scl_m),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .rw       (rw),
    .busy     (busy)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] wr_bytes[$];
  logic [7:0] tx_pool[256];
  logic [7:0] tx_ptr    = 8'd0;   // client side
  logic [7:0] model_ptr = 8'd0;   // reference model side
  bit         oe_seen   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        if (rx_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rx_unexpected actual=%0h required=none @%0t", rx_data, $time);
        end else begin
          check("rx_data", 32'(rx_data), 32'(rx_q.pop_front()));
        end
      end
      if (tx_req) begin
        if (tx_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_req_unexpected actual=%0h required=none @%0t", tx_data, $time);
        end else begin
          check("tx_capture", 32'(tx_data), 32'(tx_q.pop_front()));
        end
      end
      if (sda_oe) oe_seen = 1'b1;
    end
  end

  // ---------------- tx client ----------------
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (tx_req) tx_ptr = tx_ptr + 8'd1;
      tx_data = tx_pool[tx_ptr];
    end
  end

  // ---------------- master bus tasks ----------------
  task automatic bus_start();
    #Q; sda_m = 1'b1;
    #Q; scl_m = 1'b1;
    #Q; sda_m = 1'b0;
    #Q; scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    #Q; sda_m = 1'b0;
    #Q; scl_m = 1'b1;
    #Q; sda_m = 1'b1;
    #Q;
  endtask

  task automatic send_bit(input logic b);
    #Q; sda_m = b;
    #Q; scl_m = 1'b1;
    #(2*Q); scl_m = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    #Q; sda_m = 1'b1;
    #Q; scl_m = 1'b1;
    #Q; b = sda_bus;
    #Q; scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    read_bit(s);
    ack = ~s;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic master_ack);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(s);
      d = {d[6:0], s};
    end
    send_bit(~master_ack);
  endtask

  // Reference model: a transfer to OWN_ADDR is ACKed byte by byte; a write
  // delivers each byte once; a read returns the client's bytes in order with
  // one capture per byte; anything else is ignored entirely.
  task automatic xfer(input logic [7:0] addr, input int n);
    logic       ack;
    logic [7:0] got;
    bit         match;
    match = (addr[7:1] == OWN_ADDR);
    if (match && addr[0])
      for (int k = 0; k < n; k++) tx_q.push_back(tx_pool[8'(model_ptr + 8'(k))]);
    bus_start();
    write_byte(addr, ack);
    check("addr_ack", 32'(ack), 32'(match));
    check("busy_after_addr", 32'(busy), 32'(match));
    if (match) check("rw", 32'(rw), 32'(addr[0]));
    if (!addr[0]) begin
      foreach (wr_bytes[i]) begin
        if (match) rx_q.push_back(wr_bytes[i]);
        write_byte(wr_bytes[i], ack);
        check("data_ack", 32'(ack), 32'(match));
      end
    end else if (match) begin
      for (int k = 0; k < n; k++) begin
        read_byte(got, k != n - 1);
        check("rd_data", 32'(got), 32'(tx_pool[model_ptr]));
        model_ptr = model_ptr + 8'd1;
      end
      check("busy_after_nack", 32'(busy), 32'd0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sda_oe"},   32'(sda_oe),   32'd0);
    check({tag, "_rx_data"},  32'(rx_data),  32'd0);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_tx_req"},   32'(tx_req),   32'd0);
    check({tag, "_rw"},       32'(rw),       32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic       dummy;
    logic [7:0] a;
    int         n;
    foreach (tx_pool[i]) tx_pool[i] = 8'($urandom);
    tx_data = tx_pool[0];
    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Write 0xA5, 0x3C
    wr_bytes = '{8'hA5, 8'h3C};
    xfer(8'hA0, 0);
    check("busy_before_stop", 32'(busy), 32'd1);
    bus_stop();
    check("busy_after_stop", 32'(busy), 32'd0);

    // Read 0x96, 0x0F (ACK then NACK)
    tx_pool[model_ptr] = 8'h96;
    tx_pool[8'(model_ptr + 8'd1)] = 8'h0F;
    xfer(8'hA1, 2);
    bus_stop();

    // Address mismatch: never touches SDA
    oe_seen = 1'b0;
    wr_bytes = '{8'h55};
    xfer(8'hA2, 0);
    bus_stop();
    check("mismatch_oe_seen", 32'(oe_seen), 32'd0);
    check("mismatch_busy", 32'(busy), 32'd0);

    // Repeated START: write 0x10, Sr, read one byte
    wr_bytes = '{8'h10};
    xfer(8'hA0, 0);
    xfer(8'hA1, 1);
    bus_stop();
    check("sr_rx_data", 32'(rx_data), 32'h10);
    check("sr_rw", 32'(rw), 32'd1);

    // Randomised transfers, including general call and foreign addresses
    for (int t = 0; t < 12; t++) begin
      case ($urandom_range(0, 3))
        0, 1:    a = {OWN_ADDR, 1'($urandom)};
        2: begin
          a[7:1] = 7'($urandom);
          if (a[7:1] == OWN_ADDR) a[7:1] = OWN_ADDR + 7'd1;
          a[0] = 1'($urandom);
        end
        default: a = {7'h00, 1'($urandom)};
      endcase
      n = $urandom_range(1, 3);
      wr_bytes.delete();
      for (int k = 0; k < n; k++) wr_bytes.push_back(8'($urandom));
      oe_seen = 1'b0;
      xfer(a, n);
      bus_stop();
      check("rand_busy_idle", 32'(busy), 32'd0);
      if (a[7:1] != OWN_ADDR) check("rand_mismatch_oe", 32'(oe_seen), 32'd0);
    end

    // Abort: STOP after 4 data bits of a write discards the partial byte
    bus_start();
    write_byte(8'hA0, dummy);
    check("abort_addr_ack", 32'(dummy), 32'd1);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    bus_stop();
    check("abort_busy", 32'(busy), 32'd0);

    // Reset during the ADDR phase of a new transfer
    bus_start();
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    #3; rst_n = 1'b0;
    #1;
    check_reset_values("addr_rst");
    #6; repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bus_stop();

    // Reset while the target is pulling SDA for the address ACK
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b0 : OWN_ADDR[i-1]);
    #(2*Q);
    check("ack_drive_before_rst", 32'(sda_oe), 32'd1);
    #3; rst_n = 1'b0;
    #1;
    check("async_release", 32'(sda_oe), 32'd0);
    check_reset_values("ack_rst");
    #6; repeat (3) @(negedge clk);
    rst_n = 1'b1;
    scl_m = 1'b0;
    bus_stop();
    repeat (8) @(negedge clk);

    check("rx_q_drained", 32'(rx_q.size()), 32'd0);
    check("tx_q_drained", 32'(tx_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
